mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, computing MULT/MULTU/DIV/DIVU into HI/LO.
- Sits directly downstream of register_file: operand_a/operand_b are driven from read_data1/read_data2.
- HI/LO results return to the register file write port via MFHI/MFLO through the write-back mux.
- Multi-cycle; the controller stalls the pipeline on busy.

---
 rtl/mult_div_unit_pkg.sv | 35 +++
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit_sign_fix.sv | 17 +
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit. It holds the
// operation codes, the FSM state encodings, the zero word used at reset, and
// small decode helpers for the op field.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  // Operation codes as they arrive on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  // MULT and DIV (op[0] == 0) are the two's-complement variants.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // DIV and DIVU (op[1] == 1) are the divide variants.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the pipeline controller (master) and the
// multiply/divide unit (slave).
//   start, op, operand_a, operand_b : request, driven by the master
//   busy, done, div_by_zero, hi, lo : status and result, driven by the unit
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// md_sign_fix
// Combinational conditional two's-complement negate. It is used to take
// operand magnitudes at load time and to restore result signs in FIX.
//   i_val : value in
//   i_neg : 1 = negate
//   o_val : i_neg ? -i_val : i_val
// -----------------------------------------------------------------------------
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative MULT/MULTU/DIV/DIVU unit that writes HI/LO. The unit takes one
// shift-add step or one restoring shift-subtract step per cycle, for WIDTH
// cycles. A final FIX cycle restores the signs and commits hi/lo.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_div_unit_if.slave, which carries the request
//           (start/op/operand_a/operand_b) and the status/result
//           (busy/done/div_by_zero/hi/lo)
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_div_unit_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_res;   // quotient / product is negative
  logic             r_neg_rem;   // remainder follows the dividend's sign
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_acc;       // product high half / partial remainder
  logic [WIDTH-1:0] r_work;      // multiplier-then-product-low / dividend-then-quotient
  logic [WIDTH-1:0] r_b;         // multiplicand / divisor magnitude
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_a_neg    = is_signed_op(bus.op) & bus.operand_a[WIDTH-1];
  assign w_b_neg    = is_signed_op(bus.op) & bus.operand_b[WIDTH-1];
  assign w_div_zero = is_div_op(bus.op) && (bus.operand_b == '0);

  md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.i_val(bus.operand_a), .i_neg(w_a_neg), .o_val(w_a_mag));
  md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.i_val(bus.operand_b), .i_neg(w_b_neg), .o_val(w_b_mag));

  // The multiply step adds the multiplicand into the high half. The extra
  // bit keeps the carry, which shifts down into the MSB.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_b};
  // The divide step brings the next dividend bit into the partial remainder
  // and does a trial subtract. The remainder stays below the divisor, so
  // w_diff[WIDTH] is set exactly when the trial subtract borrows.
  assign w_shift = {r_acc, r_work[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.i_val({r_acc, r_work}), .i_neg(r_neg_res), .o_val(w_prod_fix));
  md_sign_fix #(.WIDTH(WIDTH))   u_fix_quo  (.i_val(r_work), .i_neg(r_neg_res), .o_val(w_quo_fix));
  md_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.i_val(r_acc),  .i_neg(r_neg_rem), .o_val(w_rem_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: working registers are reset along with the outputs so that a
      // reset mid-operation leaves no stale state behind.
      r_state    <= MD_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_acc      <= '0;
      r_work     <= '0;
      r_b        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= WIDTH'(WORD_ZERO);
      r_lo       <= WIDTH'(WORD_ZERO);
    end else begin
      // NOTE: non-blocking everywhere, so every right-hand side reads the
      // value from before the edge, whatever the statement order.
      r_done <= 1'b0;
      unique case (r_state)
        MD_IDLE: begin
          if (bus.start) begin
            r_is_div   <= is_div_op(bus.op);
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_dbz_pend <= w_div_zero;
            r_acc      <= '0;
            r_work     <= w_a_mag;
            r_b        <= w_b_mag;
            r_cnt      <= CW'(WIDTH);
            r_busy     <= 1'b1;
            r_dbz      <= 1'b0;
            r_state    <= w_div_zero ? MD_FIX : MD_CALC;
          end
        end
        MD_CALC: begin
          if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
              r_acc  <= w_diff[WIDTH-1:0];
              r_work <= {r_work[WIDTH-2:0], 1'b1};
            end else begin
              r_acc  <= w_shift[WIDTH-1:0];
              r_work <= {r_work[WIDTH-2:0], 1'b0};
            end
          end else if (r_work[0]) begin
            r_acc  <= w_sum[WIDTH:1];
            r_work <= {w_sum[0], r_work[WIDTH-1:1]};
          end else begin
            r_acc  <= {1'b0, r_acc[WIDTH-1:1]};
            r_work <= {r_acc[0], r_work[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= MD_FIX;
        end
        MD_FIX: begin
          // A divide by zero leaves hi/lo exactly as they were.
          if (!r_dbz_pend) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
          r_dbz   <= r_dbz_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed and random checks of mult_div_unit against an arithmetic reference
// model. The model uses 64-bit integer multiply, divide and modulo.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc;
  int busy_cnt;
  int exp_lat;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic        m_dbz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model. It holds the architectural HI/LO and updates them from
  // plain arithmetic on the request.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sq, sr;
    m_dbz   = 1'b0;
    exp_lat = W + 1;
    case (op)
      OP_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 32'h0) begin
          m_dbz = 1'b1; exp_lat = 1;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      default: begin
        if (b == 32'h0) begin
          m_dbz = 1'b1; exp_lat = 1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_op;
    if (bus.busy === 1'b1) busy_cnt++;
    tick();
    cyc++;
  endtask

  // Presents a request for one edge, then scrambles the inputs while busy.
  task automatic launch(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.start = 1'b1;
    model(op, a, b);
    tick();
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
    cyc = 0; busy_cnt = 0;
    check({tag, ".busy_on_accept"}, 64'(bus.busy), 64'd1);
    check({tag, ".dbz_cleared"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  // Waits (bounded) for done and compares latency, busy width and results.
  task automatic wait_done(input string tag);
    while (bus.done !== 1'b1 && cyc < 100) tick_op();
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
    check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(m_dbz));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst_n = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.dbz", 64'(bus.div_by_zero), 64'd0);
    check("reset.hi", 64'(bus.hi), 64'd0);
    check("reset.lo", 64'(bus.lo), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Full-scale unsigned product, with the done pulse one cycle wide.
    launch("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    check("multu_max.hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max.lo_const", 64'(bus.lo), 64'h0000_0001);
    tick();
    check("multu_max.done_one_cycle", 64'(bus.done), 64'd0);
    check("multu_max.hi_hold", 64'(bus.hi), 64'hFFFF_FFFE);

    launch("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg");
    check("mult_neg.lo_const", 64'(bus.lo), 64'hFFFF_FFEB);

    launch("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg");
    check("div_neg.lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_neg.hi_const", 64'(bus.hi), 64'hFFFF_FFFF);

    launch("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    check("div_ovf.lo_const", 64'(bus.lo), 64'h8000_0000);

    launch("divu", OP_DIVU, 32'd100, 32'd7);
    wait_done("divu");
    check("divu.lo_const", 64'(bus.lo), 64'd14);

    // Divide by zero: one-cycle latency with hi/lo left untouched.
    launch("div_zero", OP_DIV, 32'd5, 32'd0);
    wait_done("div_zero");
    check("div_zero.hi_const", 64'(bus.hi), 64'd2);
    tick();

    // A second start while busy must be ignored. The next start, taken in
    // the done cycle, must be accepted.
    launch("multu_ign", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) tick_op();
    bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd77; bus.operand_b = 32'd5;
    tick_op();
    bus.start = 1'b0;
    wait_done("multu_ign");
    launch("b2b_divu", OP_DIVU, 32'd9, 32'd3);
    wait_done("b2b_divu");
    check("b2b_divu.lo_const", 64'(bus.lo), 64'd3);

    // Asynchronous reset in the middle of CALC.
    launch("rst_mid", OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (14) tick_op();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.done", 64'(bus.done), 64'd0);
    check("rst_mid.hi", 64'(bus.hi), 64'd0);
    check("rst_mid.lo", 64'(bus.lo), 64'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    #13 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("rst_mid.no_done", 64'(pulses), 64'd0);
    check("rst_mid.idle_busy", 64'(bus.busy), 64'd0);
    launch("post_rst", OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done("post_rst");

    // Random mix, sometimes back-to-back and sometimes with idle gaps.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = pick_val();
      r_b  = ($urandom_range(0, 5) == 0) ? 32'h0 : pick_val();
      launch($sformatf("rand%0d", i), r_op, r_a, r_b);
      wait_done($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
